// File: rtl/axi_hp0_mem_responder.sv
// AXI3 subordinate backed by a word-addressed byte-lane RAM, standing in for PS DDR behind HP0.
// One read and one write burst may be in flight at once; INCR/FIXED only, everything else answers SLVERR.

module axi_hp0_mem_lane #(
  parameter int DEPTH = 4096,
  parameter int IW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  // Same-cycle read of a word being written returns the old byte.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module axi_hp0_mem_responder #(
  parameter int C_HP0_AXI_DATA_WIDTH = 64,
  parameter int C_HP0_AXI_ADDR_WIDTH = 32,
  parameter int ID_WIDTH             = 6,
  parameter int MEM_ELS              = 4096,
  parameter logic [C_HP0_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 'h1000_0000
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [C_HP0_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [ID_WIDTH-1:0]             s_axi_awid,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic [1:0]                      s_axi_awlock,
  input  logic [3:0]                      s_axi_awcache,
  input  logic [2:0]                      s_axi_awprot,
  input  logic [3:0]                      s_axi_awqos,
  input  logic [C_HP0_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [ID_WIDTH-1:0]             s_axi_wid,
  input  logic                            s_axi_wlast,
  input  logic [C_HP0_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  output logic [ID_WIDTH-1:0]             s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  input  logic [C_HP0_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [ID_WIDTH-1:0]             s_axi_arid,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic [1:0]                      s_axi_arlock,
  input  logic [3:0]                      s_axi_arcache,
  input  logic [2:0]                      s_axi_arprot,
  input  logic [3:0]                      s_axi_arqos,
  output logic [C_HP0_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [ID_WIDTH-1:0]             s_axi_rid,
  output logic                            s_axi_rlast,
  output logic [1:0]                      s_axi_rresp
);
  localparam int AW    = C_HP0_AXI_ADDR_WIDTH;
  localparam int BYTES = C_HP0_AXI_DATA_WIDTH / 8;
  localparam int SH    = $clog2(BYTES);
  localparam int IW    = $clog2(MEM_ELS);
  localparam logic [AW-1:0] MEM_BYTES  = AW'(MEM_ELS * BYTES);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BYTES - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic in_range(input logic [AW-1:0] a);
    logic [AW-1:0] wa;
    wa = a & ALIGN_MASK;
    return (wa >= BASE_ADDR) && ((wa - BASE_ADDR) < MEM_BYTES);
  endfunction

  function automatic logic [IW-1:0] widx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - BASE_ADDR;
    return IW'(off >> SH);
  endfunction

  function automatic logic bad_burst(input logic [2:0] sz, input logic [1:0] bt);
    return (sz != 3'(SH)) || bt[1];
  endfunction

  // ---------------- write side ----------------
  w_state_t        w_st, w_nxt;
  logic            aw_rdy, w_rdy, b_vld;
  logic [AW-1:0]   w_addr;
  logic [ID_WIDTH-1:0] w_id;
  logic [7:0]      w_cnt;
  logic            w_incr, w_berr, w_err_q;
  logic            w_beat, w_ok, w_we, w_beat_err;

  always_ff @(posedge aclk) begin
    if (areset) w_st <= W_IDLE;
    else        w_st <= w_nxt;
  end

  always_comb begin
    w_nxt  = w_st;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    b_vld  = 1'b0;
    if (!areset) begin
      case (w_st)
        W_IDLE: begin
          aw_rdy = 1'b1;
          if (s_axi_awvalid) w_nxt = W_DATA;
        end
        W_DATA: begin
          w_rdy = 1'b1;
          if (s_axi_wvalid && w_cnt == 8'd0) w_nxt = W_RESP;
        end
        W_RESP: begin
          b_vld = 1'b1;
          if (s_axi_bready) w_nxt = W_IDLE;
        end
        default: w_nxt = W_IDLE;
      endcase
    end
  end

  assign w_beat     = w_rdy & s_axi_wvalid;
  assign w_ok       = !w_berr && in_range(w_addr);
  assign w_we       = w_beat & w_ok;
  // The burst length comes from awlen; wlast only contributes to the error status.
  assign w_beat_err = !w_ok || (s_axi_wlast != (w_cnt == 8'd0));

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_addr  <= '0;
      w_id    <= '0;
      w_cnt   <= '0;
      w_incr  <= 1'b0;
      w_berr  <= 1'b0;
      w_err_q <= 1'b0;
    end else if (aw_rdy && s_axi_awvalid) begin
      w_addr  <= s_axi_awaddr;
      w_id    <= s_axi_awid;
      w_cnt   <= s_axi_awlen;
      w_incr  <= (s_axi_awburst == 2'b01);
      w_berr  <= bad_burst(s_axi_awsize, s_axi_awburst);
      w_err_q <= 1'b0;
    end else if (w_beat) begin
      w_err_q <= w_err_q | w_beat_err;
      w_cnt   <= w_cnt - 8'd1;
      if (w_incr) w_addr <= w_addr + AW'(BYTES);
    end
  end

  assign s_axi_awready = aw_rdy;
  assign s_axi_wready  = w_rdy;
  assign s_axi_bvalid  = b_vld;
  assign s_axi_bid     = b_vld ? w_id : '0;
  assign s_axi_bresp   = b_vld ? {w_err_q, 1'b0} : 2'b00;

  // ---------------- read side ----------------
  r_state_t        r_st, r_nxt;
  logic            ar_rdy, r_vld, ar_fire, r_adv;
  logic [AW-1:0]   r_addr, rd_addr_nxt;
  logic [ID_WIDTH-1:0] r_id;
  logic [7:0]      r_len, r_cnt;
  logic            r_incr, r_berr, r_ok_q, r_last_q;
  logic            rd_berr_nxt, rd_ok, rd_en;

  always_ff @(posedge aclk) begin
    if (areset) r_st <= R_IDLE;
    else        r_st <= r_nxt;
  end

  always_comb begin
    r_nxt  = r_st;
    ar_rdy = 1'b0;
    r_vld  = 1'b0;
    if (!areset) begin
      case (r_st)
        R_IDLE: begin
          ar_rdy = 1'b1;
          if (s_axi_arvalid) r_nxt = R_DATA;
        end
        R_DATA: begin
          r_vld = 1'b1;
          if (s_axi_rready && r_last_q) r_nxt = R_IDLE;
        end
        default: r_nxt = R_IDLE;
      endcase
    end
  end

  // The RAM output register is the rdata holding register: it is only
  // re-read on a handshake, so stalled beats stay stable and accepted ones
  // are followed without a bubble.
  assign ar_fire     = ar_rdy & s_axi_arvalid;
  assign r_adv       = r_vld & s_axi_rready & !r_last_q;
  assign rd_addr_nxt = ar_fire ? s_axi_araddr : (r_incr ? r_addr + AW'(BYTES) : r_addr);
  assign rd_berr_nxt = ar_fire ? bad_burst(s_axi_arsize, s_axi_arburst) : r_berr;
  assign rd_ok       = !rd_berr_nxt && in_range(rd_addr_nxt);
  assign rd_en       = (ar_fire | r_adv) & rd_ok;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_addr   <= '0;
      r_id     <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_incr   <= 1'b0;
      r_berr   <= 1'b0;
      r_ok_q   <= 1'b0;
      r_last_q <= 1'b0;
    end else begin
      if (ar_fire) begin
        r_id   <= s_axi_arid;
        r_len  <= s_axi_arlen;
        r_cnt  <= '0;
        r_incr <= (s_axi_arburst == 2'b01);
        r_berr <= rd_berr_nxt;
      end else if (r_adv) begin
        r_cnt  <= r_cnt + 8'd1;
      end
      if (ar_fire || r_adv) begin
        r_addr   <= rd_addr_nxt;
        r_ok_q   <= rd_ok;
        r_last_q <= ar_fire ? (s_axi_arlen == 8'd0) : (r_cnt + 8'd1 == r_len);
      end
    end
  end

  logic [BYTES-1:0][7:0] ram_q;
  logic [IW-1:0]         w_idx, rd_idx;
  assign w_idx  = widx(w_addr);
  assign rd_idx = widx(rd_addr_nxt);

  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    axi_hp0_mem_lane #(.DEPTH(MEM_ELS), .IW(IW)) u_lane (
      .clk   (aclk),
      .we    (w_we & s_axi_wstrb[b]),
      .waddr (w_idx),
      .wdata (s_axi_wdata[8*b +: 8]),
      .re    (rd_en),
      .raddr (rd_idx),
      .rdata (ram_q[b])
    );
  end

  assign s_axi_arready = ar_rdy;
  assign s_axi_rvalid  = r_vld;
  assign s_axi_rdata   = (r_vld && r_ok_q) ? ram_q : '0;
  assign s_axi_rid     = r_vld ? r_id : '0;
  assign s_axi_rresp   = (r_vld && !r_ok_q) ? 2'b10 : 2'b00;
  assign s_axi_rlast   = r_vld & r_last_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_wid, 1'b0};
endmodule

// File: tb/tb_axi_hp0_mem_responder.sv
// Scoreboard bench: stimulus tasks push expected B/R responses from a word-level memory model,
// a negedge monitor pops and compares them as the DUT presents responses.
module tb_axi_hp0_mem_responder;
  localparam int DW = 64, AW = 32, IDW = 6, MEM_ELS = 4096;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic aclk, areset;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, arvalid, arready;
  logic [IDW-1:0] awid, arid, wid, bid, rid;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, awlock, arlock, bresp, rresp;
  logic [3:0] awcache, arcache, awqos, arqos;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic wvalid, wready, wlast, bvalid, bready, rvalid, rready, rlast;

  axi_hp0_mem_responder #(.C_HP0_AXI_DATA_WIDTH(DW), .C_HP0_AXI_ADDR_WIDTH(AW), .ID_WIDTH(IDW),
    .MEM_ELS(MEM_ELS), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid),
    .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(awlock),
    .s_axi_awcache(awcache), .s_axi_awprot(awprot), .s_axi_awqos(awqos),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wid(wid),
    .s_axi_wlast(wlast), .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid),
    .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(arlock),
    .s_axi_arcache(arcache), .s_axi_arprot(arprot), .s_axi_arqos(arqos),
    .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid),
    .s_axi_rlast(rlast), .s_axi_rresp(rresp));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [IDW-1:0] id; logic [63:0] data; logic [1:0] resp; logic last; bit chk_data; } rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];
  logic [63:0] model [int];
  int n_chk = 0, n_fail = 0, r_acc = 0, rr_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no response within bound / unexpected response", nm);
  endtask

  function automatic bit m_ok(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & ~32'h7;
    return (wa >= BASE) && ((wa - BASE) < 32'(MEM_ELS * 8));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'(((a & ~32'h7) - BASE) >> 3);
  endfunction

  // ready drivers
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rr_mode)
        0: rready = 1'b1;
        1: rready = ~rready;
        default: rready = 1'($urandom % 2);
      endcase
      bready = ($urandom % 4) != 0;
    end
  end

  // monitor
  initial begin
    bexp_t be;
    rexp_t re;
    bit hold = 0;
    logic [63:0] p_data;
    logic [1:0] p_resp;
    logic p_last;
    logic [IDW-1:0] p_id;
    forever begin
      @(negedge aclk);
      if (areset) hold = 0;
      else begin
        if (hold) begin
          chk("r_stall_valid", 64'(rvalid), 64'd1);
          chk("r_stall_data", rdata, p_data);
          chk("r_stall_resp", 64'(rresp), 64'(p_resp));
          chk("r_stall_last", 64'(rlast), 64'(p_last));
          chk("r_stall_id", 64'(rid), 64'(p_id));
        end
        if (bvalid && bready) begin
          if (bq.size() == 0) fail("b_unexpected");
          else begin
            be = bq.pop_front();
            chk("bid", 64'(bid), 64'(be.id));
            chk("bresp", 64'(bresp), 64'(be.resp));
          end
        end
        if (rvalid && rready) begin
          r_acc++;
          if (rq.size() == 0) fail("r_unexpected");
          else begin
            re = rq.pop_front();
            chk("rid", 64'(rid), 64'(re.id));
            chk("rresp", 64'(rresp), 64'(re.resp));
            chk("rlast", 64'(rlast), 64'(re.last));
            if (re.chk_data) chk("rdata", rdata, re.data);
          end
        end
        hold = rvalid && !rready;
        p_data = rdata; p_resp = rresp; p_last = rlast; p_id = rid;
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [63:0] d[$], input logic [7:0] s[$],
                          input int bad_last);
    logic [IDW-1:0] id;
    logic [31:0] ca;
    logic [63:0] w;
    bit berr, err, ok;
    bexp_t e;
    int t, idx;
    id = IDW'($urandom);
    berr = (sz != 3'd3) || bt[1];
    err = 0;
    ca = a;
    for (int i = 0; i <= int'(len); i++) begin
      ok = !berr && m_ok(ca);
      if (ok) begin
        idx = m_idx(ca);
        if (model.exists(idx) || s[i] == 8'hFF) begin
          w = model.exists(idx) ? model[idx] : 64'h0;
          for (int b = 0; b < 8; b++) if (s[i][b]) w[8*b +: 8] = d[i][8*b +: 8];
          model[idx] = w;
        end
      end
      err |= !ok || (i == bad_last);
      if (bt == 2'b01) ca += 32'd8;
    end
    e.id = id;
    e.resp = err ? 2'b10 : 2'b00;
    bq.push_back(e);

    @(posedge aclk); #1;
    awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bt;
    awlock = 2'($urandom); awcache = 4'($urandom); awprot = 3'($urandom); awqos = 4'($urandom);
    t = 0;
    do begin @(negedge aclk); t++; end while (!awready && t < 100);
    if (!awready) fail("aw_timeout");
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom % 3 == 0) begin wvalid = 1'b0; @(posedge aclk); #1; end
      wvalid = 1'b1; wdata = d[i]; wstrb = s[i]; wid = id;
      wlast = (i == bad_last) ? (i != int'(len)) : (i == int'(len));
      t = 0;
      do begin @(negedge aclk); t++; end while (!wready && t < 100);
      if (!wready) fail("w_timeout");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge aclk);
    chk("bvalid_latency", 64'(bvalid), 64'd1);
    t = 0;
    while (bq.size() != 0 && t < 200) begin @(negedge aclk); t++; end
    if (bq.size() != 0) begin fail("b_timeout"); bq.delete(); end
  endtask

  task automatic rd_issue(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt);
    logic [IDW-1:0] id;
    logic [31:0] ca;
    bit berr, ok;
    rexp_t e;
    int t;
    id = IDW'($urandom);
    berr = (sz != 3'd3) || bt[1];
    ca = a;
    for (int i = 0; i <= int'(len); i++) begin
      ok = !berr && m_ok(ca);
      e.id = id;
      e.resp = ok ? 2'b00 : 2'b10;
      e.last = (i == int'(len));
      e.chk_data = !ok || model.exists(m_idx(ca));
      e.data = (ok && model.exists(m_idx(ca))) ? model[m_idx(ca)] : 64'h0;
      rq.push_back(e);
      if (bt == 2'b01) ca += 32'd8;
    end
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = sz; arburst = bt;
    arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom); arqos = 4'($urandom);
    t = 0;
    do begin @(negedge aclk); t++; end while (!arready && t < 100);
    if (!arready) fail("ar_timeout");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk);
    chk("rvalid_latency", 64'(rvalid), 64'd1);
  endtask

  task automatic rd_wait();
    int t = 0;
    while (rq.size() != 0 && t < 400) begin @(negedge aclk); t++; end
    if (rq.size() != 0) begin fail("r_timeout"); rq.delete(); end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt);
    rd_issue(a, len, sz, bt);
    rd_wait();
  endtask

  task automatic fill_write(input logic [31:0] a, input logic [7:0] len, input int mode);
    logic [63:0] d[$];
    logic [7:0] s[$];
    for (int i = 0; i <= int'(len); i++) begin
      d.push_back(mode == 0 ? {$urandom, $urandom} : 64'(i * 3));
      s.push_back(8'hFF);
    end
    do_write(a, len, 3'd3, 2'b01, d, s, -1);
  endtask

  task automatic rand_op(input bit is_wr, input int region_max);
    logic [31:0] a;
    logic [7:0] len;
    logic [2:0] sz;
    logic [1:0] bt;
    logic [63:0] d[$];
    logic [7:0] s[$];
    int r, bad;
    r = int'($urandom % 32'(region_max));
    if (r <= 6)      a = BASE + 32'(($urandom % 120) * 8) + ($urandom % 8);
    else if (r == 7) a = BASE + 32'((4090 + $urandom % 6) * 8);
    else if (r == 8) a = BASE - 32'((1 + $urandom % 3) * 8);
    else             a = 32'h2000_0000;
    len = 8'($urandom % 8);
    sz = ($urandom % 8 == 0) ? 3'd2 : 3'd3;
    r = int'($urandom % 10);
    bt = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
    rr_mode = int'($urandom % 3);
    if (is_wr) begin
      for (int i = 0; i <= int'(len); i++) begin
        d.push_back({$urandom, $urandom});
        s.push_back(($urandom % 2 == 0) ? 8'hFF : 8'($urandom));
      end
      bad = ($urandom % 5 == 0) ? int'($urandom % (32'(len) + 1)) : -1;
      do_write(a, len, sz, bt, d, s, bad);
    end else begin
      do_read(a, len, sz, bt);
    end
  endtask

  initial begin
    logic [63:0] d[$];
    logic [7:0] s[$];
    int t, start;
    areset = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; wlast = 0;
    awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    awlock = 0; awcache = 0; awprot = 0; awqos = 0;
    araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    arlock = 0; arcache = 0; arprot = 0; arqos = 0;
    wdata = 0; wstrb = 0; wid = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", 64'(awready), 0); chk("rst_arready", 64'(arready), 0);
    chk("rst_wready", 64'(wready), 0);   chk("rst_bvalid", 64'(bvalid), 0);
    chk("rst_rvalid", 64'(rvalid), 0);   chk("rst_rdata", rdata, 0);
    chk("rst_rid", 64'(rid), 0);         chk("rst_bid", 64'(bid), 0);
    chk("rst_bresp", 64'(bresp), 0);     chk("rst_rresp", 64'(rresp), 0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // basic single write and readback
    d = '{64'hDEAD_BEEF_0123_4567}; s = '{8'hFF};
    do_write(BASE, 8'd0, 3'd3, 2'b01, d, s, -1);
    rr_mode = 0;
    do_read(BASE, 8'd0, 3'd3, 2'b01);

    // 8-beat INCR with rready toggling
    fill_write(BASE + 32'h40, 8'd7, 1);
    rr_mode = 1;
    do_read(BASE + 32'h40, 8'd7, 3'd3, 2'b01);

    // just past the top of RAM; word 0 must survive
    fill_write(BASE + 32'(MEM_ELS * 8), 8'd1, 0);
    do_read(BASE + 32'(MEM_ELS * 8), 8'd1, 3'd3, 2'b01);
    rr_mode = 0;
    do_read(BASE, 8'd0, 3'd3, 2'b01);

    // byte strobes
    d = '{64'hFFFF_FFFF_FFFF_FFFF}; s = '{8'hFF};
    do_write(BASE + 32'h100, 8'd0, 3'd3, 2'b01, d, s, -1);
    d = '{64'h0}; s = '{8'h0F};
    do_write(BASE + 32'h100, 8'd0, 3'd3, 2'b01, d, s, -1);
    do_read(BASE + 32'h100, 8'd0, 3'd3, 2'b01);

    // initialise the regions the random phase reads
    for (int k = 0; k < 8; k++) fill_write(BASE + 32'(k * 128), 8'd15, 0);
    fill_write(BASE + 32'((MEM_ELS - 8) * 8), 8'd7, 0);

    for (int k = 0; k < 40; k++) rand_op(1'($urandom % 2), 10);

    // concurrent write (words 200+) and read (words 0..127)
    for (int k = 0; k < 4; k++) begin
      d.delete(); s.delete();
      for (int i = 0; i < 8; i++) begin d.push_back({$urandom, $urandom}); s.push_back(8'hFF); end
      rr_mode = 2;
      fork
        do_write(BASE + 32'((200 + k * 8) * 8), 8'd7, 3'd3, 2'b01, d, s, -1);
        do_read(BASE + 32'(($urandom % 100) * 8), 8'd7, 3'd3, 2'b01);
      join
    end

    // reset in the middle of a read burst
    rr_mode = 1;
    start = r_acc;
    rd_issue(BASE, 8'd7, 3'd3, 2'b01);
    t = 0;
    while (r_acc < start + 3 && t < 100) begin @(negedge aclk); t++; end
    if (r_acc < start + 3) fail("r_midburst_timeout");
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("midrst_rvalid", 64'(rvalid), 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_arready", 64'(arready), 0);
    rq.delete();
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("postrst_arready", 64'(arready), 1);
    chk("postrst_awready", 64'(awready), 1);
    rr_mode = 2;
    do_read(BASE + 32'h40, 8'd7, 3'd3, 2'b01);
    for (int k = 0; k < 6; k++) rand_op(1'($urandom % 2), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end
endmodule
